// File: rtl/lcd_show_glyph.sv
// Renders one font-ROM glyph for the ST7735 path: an 11-word window setup followed by RGB565 pixel bytes.
// Optional integer magnification is compiled in when LCD_GLYPH_SCALE_EN is defined.
module lcd_show_glyph #(
  parameter int GLYPH_W   = 6,
  parameter int GLYPH_H   = 12,
  parameter int FONT_BASE = 0,
  parameter int ROM_LAT   = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        show_char_flag,
  input  logic [6:0]  ascii_num,
  input  logic [8:0]  start_x,
  input  logic [8:0]  start_y,
  input  logic [15:0] fg_color,
  input  logic [15:0] bg_color,
  input  logic [1:0]  scale,
  input  logic        wr_done,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_q,
  output logic [8:0]  glyph_data,
  output logic        en_write_glyph,
  output logic        busy,
  output logic        glyph_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIN,
    S_FETCH,
    S_PIX,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  ascii_q, ascii_d;
  logic [8:0]  xs_q, xs_d;
  logic [8:0]  ys_q, ys_d;
  logic [15:0] fg_q, fg_d;
  logic [15:0] bg_q, bg_d;
  logic [3:0]  word_q, word_d;
  logic [2:0]  fetch_q, fetch_d;
  logic [4:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic        lo_q, lo_d;
  logic [7:0]  line_q, line_d;

  logic [1:0]  s_m1;
  logic        h_last;
  logic        v_last;

`ifdef LCD_GLYPH_SCALE_EN
  logic [1:0] scale_q, scale_d;
  logic [1:0] h_rep_q, h_rep_d;
  logic [1:0] v_rep_q, v_rep_d;

  assign s_m1   = scale_q;
  assign h_last = (h_rep_q == scale_q);
  assign v_last = (v_rep_q == scale_q);
`else
  logic unused_scale;

  assign unused_scale = ^scale;
  assign s_m1         = 2'd0;
  assign h_last       = 1'b1;
  assign v_last       = 1'b1;
`endif

  logic [8:0]  s_n;
  logic [8:0]  xe;
  logic [8:0]  ye;
  logic [11:0] row_addr;
  logic [15:0] pix_color;
  logic [8:0]  win_word;
  logic        col_last;
  logic        row_last;
  logic        line_end;

  // Window corners wrap mod 512; the panel clips, not this block.
  always_comb begin
    s_n       = 9'(s_m1) + 9'd1;
    xe        = xs_q + 9'(GLYPH_W) * s_n - 9'd1;
    ye        = ys_q + 9'(GLYPH_H) * s_n - 9'd1;
    row_addr  = 12'(FONT_BASE) + 12'(ascii_q) * 12'(GLYPH_H) + 12'(row_q);
    pix_color = line_q[col_q] ? fg_q : bg_q;
    col_last  = (col_q == 3'(GLYPH_W - 1));
    row_last  = (row_q == 5'(GLYPH_H - 1));
    line_end  = lo_q & h_last & col_last;
  end

  always_comb begin
    case (word_q)
      4'd0:    win_word = 9'h02A;
      4'd1:    win_word = {1'b1, 7'd0, xs_q[8]};
      4'd2:    win_word = {1'b1, xs_q[7:0]};
      4'd3:    win_word = {1'b1, 7'd0, xe[8]};
      4'd4:    win_word = {1'b1, xe[7:0]};
      4'd5:    win_word = 9'h02B;
      4'd6:    win_word = {1'b1, 7'd0, ys_q[8]};
      4'd7:    win_word = {1'b1, ys_q[7:0]};
      4'd8:    win_word = {1'b1, 7'd0, ye[8]};
      4'd9:    win_word = {1'b1, ye[7:0]};
      4'd10:   win_word = 9'h02C;
      default: win_word = 9'h000;
    endcase
  end

  // NOTE: flops take non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (show_char_flag) state_d = S_WIN;
      S_WIN:   if (wr_done && word_q == 4'd10) state_d = S_FETCH;
      S_FETCH: if (fetch_q == 3'(ROM_LAT)) state_d = S_PIX;
      S_PIX: begin
        if (wr_done && line_end && v_last) begin
          state_d = row_last ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    glyph_data     = 9'h000;
    en_write_glyph = 1'b0;
    busy           = 1'b0;
    glyph_done     = 1'b0;
    rom_addr       = 12'h000;
    case (state_q)
      S_WIN: begin
        en_write_glyph = 1'b1;
        busy           = 1'b1;
        glyph_data     = win_word;
      end
      S_FETCH: begin
        busy     = 1'b1;
        rom_addr = row_addr;
      end
      S_PIX: begin
        en_write_glyph = 1'b1;
        busy           = 1'b1;
        glyph_data     = lo_q ? {1'b1, pix_color[7:0]} : {1'b1, pix_color[15:8]};
      end
      S_DONE:  glyph_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ascii_d = ascii_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    fg_d    = fg_q;
    bg_d    = bg_q;
    word_d  = word_q;
    fetch_d = fetch_q;
    row_d   = row_q;
    col_d   = col_q;
    lo_d    = lo_q;
    line_d  = line_q;
    case (state_q)
      S_IDLE: begin
        if (show_char_flag) begin
          ascii_d = ascii_num;
          xs_d    = start_x;
          ys_d    = start_y;
          fg_d    = fg_color;
          bg_d    = bg_color;
          word_d  = 4'd0;
          fetch_d = 3'd0;
          row_d   = 5'd0;
          col_d   = 3'd0;
          lo_d    = 1'b0;
        end
      end
      S_WIN: begin
        if (wr_done) word_d = word_q + 4'd1;
      end
      S_FETCH: begin
        fetch_d = fetch_q + 3'd1;
        if (fetch_q == 3'(ROM_LAT)) begin
          fetch_d = 3'd0;
          line_d  = rom_q;
        end
      end
      S_PIX: begin
        if (wr_done) begin
          lo_d = ~lo_q;
          if (lo_q && h_last) begin
            col_d = col_last ? 3'd0 : col_q + 3'd1;
            if (col_last && v_last) row_d = row_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ascii_q <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      fg_q    <= '0;
      bg_q    <= '0;
      word_q  <= '0;
      fetch_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      lo_q    <= 1'b0;
      line_q  <= '0;
    end else begin
      ascii_q <= ascii_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      word_q  <= word_d;
      fetch_q <= fetch_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lo_q    <= lo_d;
      line_q  <= line_d;
    end
  end

`ifdef LCD_GLYPH_SCALE_EN
  // Horizontal repeats step per finished pixel pair; vertical repeats per finished row line.
  always_comb begin
    scale_d = scale_q;
    h_rep_d = h_rep_q;
    v_rep_d = v_rep_q;
    if (state_q == S_IDLE && show_char_flag) begin
      scale_d = scale;
      h_rep_d = 2'd0;
      v_rep_d = 2'd0;
    end else if (state_q == S_PIX && wr_done && lo_q) begin
      h_rep_d = h_last ? 2'd0 : h_rep_q + 2'd1;
      if (h_last && col_last) v_rep_d = v_last ? 2'd0 : v_rep_q + 2'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scale_q <= '0;
      h_rep_q <= '0;
      v_rep_q <= '0;
    end else begin
      scale_q <= scale_d;
      h_rep_q <= h_rep_d;
      v_rep_q <= v_rep_d;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_show_glyph.sv
// Randomized bench for lcd_show_glyph: a list-based reference of the expected word stream and ROM rows.
module tb_lcd_show_glyph;

  localparam int GW = 6;
  localparam int GH = 12;
  localparam int FB = 100;
  localparam int RL = 3;

  logic        sys_clk        = 1'b0;
  logic        sys_rst        = 1'b1;
  logic        show_char_flag = 1'b0;
  logic [6:0]  ascii_num      = '0;
  logic [8:0]  start_x        = '0;
  logic [8:0]  start_y        = '0;
  logic [15:0] fg_color       = '0;
  logic [15:0] bg_color       = '0;
  logic [1:0]  scale          = '0;
  logic        wr_done        = 1'b0;
  logic [11:0] rom_addr;
  logic [7:0]  rom_q;
  logic [8:0]  glyph_data;
  logic        en_write_glyph;
  logic        busy;
  logic        glyph_done;

  int tests = 0;
  int fails = 0;

  logic [7:0]  rom_mem   [4096];
  logic [11:0] addr_pipe [RL];
  logic [8:0]  exp_q     [$];

  lcd_show_glyph #(
    .GLYPH_W   (GW),
    .GLYPH_H   (GH),
    .FONT_BASE (FB),
    .ROM_LAT   (RL)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .show_char_flag (show_char_flag),
    .ascii_num      (ascii_num),
    .start_x        (start_x),
    .start_y        (start_y),
    .fg_color       (fg_color),
    .bg_color       (bg_color),
    .scale          (scale),
    .wr_done        (wr_done),
    .rom_addr       (rom_addr),
    .rom_q          (rom_q),
    .glyph_data     (glyph_data),
    .en_write_glyph (en_write_glyph),
    .busy           (busy),
    .glyph_done     (glyph_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Font ROM with RL cycles of address-to-data latency.
  always @(posedge sys_clk) begin
    addr_pipe[0] <= rom_addr;
    for (int i = 1; i < RL; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign rom_q = rom_mem[addr_pipe[RL-1]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_scale(input logic [1:0] sc);
`ifdef LCD_GLYPH_SCALE_EN
    return int'(sc) + 1;
`else
    return 1;
`endif
  endfunction

  function automatic logic [11:0] glyph_row_addr(input logic [6:0] a, input int r);
    return 12'((FB + int'(a) * GH + r) % 4096);
  endfunction

  function automatic void build_exp(input logic [6:0] a, input logic [8:0] x, input logic [8:0] y,
                                    input logic [15:0] fg, input logic [15:0] bg, input int s);
    logic [8:0]  xe;
    logic [8:0]  ye;
    logic [7:0]  b;
    logic [15:0] c;
    xe = 9'((int'(x) + GW * s - 1) % 512);
    ye = 9'((int'(y) + GH * s - 1) % 512);
    exp_q.delete();
    exp_q.push_back(9'h02A);
    exp_q.push_back({1'b1, 7'd0, x[8]});
    exp_q.push_back({1'b1, x[7:0]});
    exp_q.push_back({1'b1, 7'd0, xe[8]});
    exp_q.push_back({1'b1, xe[7:0]});
    exp_q.push_back(9'h02B);
    exp_q.push_back({1'b1, 7'd0, y[8]});
    exp_q.push_back({1'b1, y[7:0]});
    exp_q.push_back({1'b1, 7'd0, ye[8]});
    exp_q.push_back({1'b1, ye[7:0]});
    exp_q.push_back(9'h02C);
    for (int r = 0; r < GH; r++) begin
      b = rom_mem[glyph_row_addr(a, r)];
      for (int v = 0; v < s; v++)
        for (int col = 0; col < GW; col++)
          for (int h = 0; h < s; h++) begin
            c = b[col] ? fg : bg;
            exp_q.push_back({1'b1, c[15:8]});
            exp_q.push_back({1'b1, c[7:0]});
          end
    end
  endfunction

  task automatic run_glyph(input logic [6:0] a, input logic [8:0] x, input logic [8:0] y,
                           input logic [15:0] fg, input logic [15:0] bg, input logic [1:0] sc,
                           input int stall_at, input int rst_at);
    int s, total, per_row, n, wait_cnt, gap, cyc, budget, stall;
    s       = eff_scale(sc);
    build_exp(a, x, y, fg, bg, s);
    total   = exp_q.size();
    per_row = 2 * GW * s * s;

    ascii_num      = a;
    start_x        = x;
    start_y        = y;
    fg_color       = fg;
    bg_color       = bg;
    scale          = sc;
    wr_done        = 1'b0;
    show_char_flag = 1'b1;
    @(posedge sys_clk); #1;
    show_char_flag = 1'b0;
    ascii_num      = 7'($urandom);
    start_x        = 9'($urandom);
    start_y        = 9'($urandom);
    fg_color       = 16'($urandom);
    bg_color       = 16'($urandom);
    scale          = 2'($urandom);
    check("start_busy", 32'(busy), 32'd1);
    check("start_en", 32'(en_write_glyph), 32'd1);

    n        = 0;
    wait_cnt = $urandom_range(0, 2);
    gap      = 0;
    cyc      = 0;
    stall    = 0;
    budget   = total * 6 + 1000;
    while (n < total && cyc < budget) begin
      cyc++;
      if (rst_at >= 0 && n == rst_at) begin
        sys_rst        = 1'b1;
        wr_done        = 1'b0;
        show_char_flag = 1'b0;
        @(posedge sys_clk); #1;
        check("rst_en", 32'(en_write_glyph), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(glyph_data), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_done", 32'(glyph_done), 32'd0);
        sys_rst = 1'b0;
        repeat (20) begin
          @(posedge sys_clk); #1;
          check("abort_done", 32'(glyph_done), 32'd0);
          check("abort_busy", 32'(busy), 32'd0);
        end
        return;
      end
      check("done_early", 32'(glyph_done), 32'd0);
      check("busy_run", 32'(busy), 32'd1);
      if (en_write_glyph) begin
        if (gap > 0) begin
          check("row_gap", 32'(gap), 32'(RL + 1));
          gap = 0;
        end
        check($sformatf("word%0d", n), 32'(glyph_data), 32'(exp_q[n]));
        if (n == stall_at && stall < 50) begin
          stall++;
          wr_done = 1'b0;
        end else if (wait_cnt == 0) begin
          wr_done  = 1'b1;
          n++;
          wait_cnt = $urandom_range(0, 2);
        end else begin
          wr_done = 1'b0;
          wait_cnt--;
        end
      end else begin
        gap++;
        check("rom_addr", 32'(rom_addr), 32'(glyph_row_addr(a, (n - 11) / per_row)));
        wr_done = ($urandom_range(0, 3) == 0);
      end
      show_char_flag = ($urandom_range(0, 7) == 0);
      @(posedge sys_clk); #1;
    end

    check("word_count", 32'(n), 32'(total));
    check("done_pulse", 32'(glyph_done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_en", 32'(en_write_glyph), 32'd0);
    wr_done        = 1'b0;
    show_char_flag = 1'b1;
    @(posedge sys_clk); #1;
    show_char_flag = 1'b0;
    check("post_done", 32'(glyph_done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_en", 32'(en_write_glyph), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
    for (int r = 0; r < GH; r++) rom_mem[glyph_row_addr(7'h10, r)] = 8'h21;

    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_data", 32'(glyph_data), 32'd0);
    check("reset_en", 32'(en_write_glyph), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(glyph_done), 32'd0);
    check("reset_addr", 32'(rom_addr), 32'd0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    run_glyph(7'h10, 9'd10, 9'd20, 16'hF800, 16'h001F, 2'd0, -1, -1);
    run_glyph(7'($urandom), 9'd508, 9'($urandom), 16'($urandom), 16'($urandom), 2'd0, -1, -1);
    run_glyph(7'($urandom), 9'($urandom), 9'($urandom), 16'($urandom), 16'($urandom), 2'd0, 40, -1);
    run_glyph(7'($urandom), 9'($urandom), 9'($urandom), 16'($urandom), 16'($urandom), 2'd0, -1, 60);
    run_glyph(7'($urandom), 9'($urandom), 9'($urandom), 16'($urandom), 16'($urandom), 2'd0, -1, -1);
    run_glyph(7'h10, 9'd10, 9'd20, 16'hF800, 16'h001F, 2'd3, -1, -1);
    repeat (4) begin
      run_glyph(7'($urandom), 9'($urandom), 9'($urandom), 16'($urandom), 16'($urandom),
                2'($urandom), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
